// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner. Each channel has a two-flop synchroniser,
// a debounce in both directions, press/release strobes and an optional typematic auto-repeat.
module button_conditioner #(
   parameter int NUM_CH          = 5,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int HOLD_CYCLES     = 25000000,
   parameter int REPEAT_CYCLES   = 10000000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_CH-1:0] button_in,
   input  logic [NUM_CH-1:0] repeat_en,
   output logic [NUM_CH-1:0] button_level,
   output logic [NUM_CH-1:0] button_press,
   output logic [NUM_CH-1:0] button_release,
   output logic [NUM_CH-1:0] button_repeat
);

   localparam int HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int STABLE_W = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int HOLD_W   = $clog2(HOLD_MAX) + 1;

   localparam logic [STABLE_W-1:0] STABLE_ONE   = STABLE_W'(1);
   localparam logic [STABLE_W-1:0] STABLE_LAST  = STABLE_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0]   HOLD_ONE     = HOLD_W'(1);
   localparam logic [HOLD_W-1:0]   HOLD_LIMIT   = HOLD_W'(HOLD_CYCLES);
   localparam logic [HOLD_W-1:0]   REPEAT_LIMIT = HOLD_W'(REPEAT_CYCLES);

   typedef enum logic [1:0] {
      RELEASED,
      PRESS_WAIT,
      HELD,
      RELEASE_WAIT
   } state_e;

   logic [NUM_CH-1:0] sync1_q;
   logic [NUM_CH-1:0] sync2_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= button_in;
         sync2_q <= sync1_q;
      end
   end

   for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
      state_e              state_q, state_d;
      logic [STABLE_W-1:0] stable_q, stable_d;
      logic [HOLD_W-1:0]   hold_q, hold_d;
      logic                repeating_q, repeating_d;
      logic                level_q, level_d;
      logic                press_q, press_d;
      logic                release_q, release_d;
      logic                repeat_q, repeat_d;
      logic                syncBit;
      logic [HOLD_W-1:0]   holdLimit;

      assign syncBit   = sync2_q[ch];
      // The first strobe waits the full hold time; later ones use the shorter repeat period.
      assign holdLimit = repeating_q ? REPEAT_LIMIT : HOLD_LIMIT;

      always_ff @(posedge clk) begin
         if (!reset) begin
            state_q     <= RELEASED;
            stable_q    <= '0;
            hold_q      <= '0;
            repeating_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            repeat_q    <= 1'b0;
         end else begin
            state_q     <= state_d;
            stable_q    <= stable_d;
            hold_q      <= hold_d;
            repeating_q <= repeating_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            repeat_q    <= repeat_d;
         end
      end

      always_comb begin
         state_d = state_q;
         unique case (state_q)
            RELEASED: begin
               if (syncBit) state_d = PRESS_WAIT;
            end
            PRESS_WAIT: begin
               if (!syncBit)                    state_d = RELEASED;
               else if (stable_q == STABLE_LAST) state_d = HELD;
            end
            HELD: begin
               if (!syncBit) state_d = RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
               if (syncBit)                     state_d = HELD;
               else if (stable_q == STABLE_LAST) state_d = RELEASED;
            end
            default: state_d = RELEASED;
         endcase
      end

      // Counters and registered strobes; the hold count is left untouched outside HELD
      // so a bounce back from RELEASE_WAIT resumes the repeat timing where it stopped.
      always_comb begin
         stable_d    = '0;
         hold_d      = hold_q;
         repeating_d = repeating_q;
         level_d     = level_q;
         press_d     = 1'b0;
         release_d   = 1'b0;
         repeat_d    = 1'b0;
         unique case (state_q)
            RELEASED: begin
               if (syncBit) stable_d = STABLE_ONE;
            end
            PRESS_WAIT: begin
               if (syncBit) begin
                  if (stable_q == STABLE_LAST) begin
                     level_d     = 1'b1;
                     press_d     = 1'b1;
                     hold_d      = '0;
                     repeating_d = 1'b0;
                  end else begin
                     stable_d = stable_q + STABLE_ONE;
                  end
               end
            end
            HELD: begin
               if (!syncBit) begin
                  stable_d = STABLE_ONE;
               end else if (!repeat_en[ch]) begin
                  hold_d      = '0;
                  repeating_d = 1'b0;
               end else if (hold_q + HOLD_ONE == holdLimit) begin
                  repeat_d    = 1'b1;
                  hold_d      = '0;
                  repeating_d = 1'b1;
               end else begin
                  hold_d = hold_q + HOLD_ONE;
               end
            end
            RELEASE_WAIT: begin
               if (!syncBit) begin
                  if (stable_q == STABLE_LAST) begin
                     level_d   = 1'b0;
                     release_d = 1'b1;
                  end else begin
                     stable_d = stable_q + STABLE_ONE;
                  end
               end
            end
            default: begin
               stable_d = '0;
            end
         endcase
      end

      assign button_level[ch]   = level_q;
      assign button_press[ch]   = press_q;
      assign button_release[ch] = release_q;
      assign button_repeat[ch]  = repeat_q;
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: stimulus pushes per-edge expectations from a
// sample-window reference model, and a negedge monitor pops and compares every cycle.
module tb_button_conditioner;

   localparam int NCH   = 3;
   localparam int DEB   = 4;
   localparam int HOLDC = 10;
   localparam int REP   = 5;
   localparam logic [31:0] WIN = (32'd1 << DEB) - 32'd1;

   logic           clk = 1'b0;
   logic           reset;
   logic [NCH-1:0] button_in;
   logic [NCH-1:0] repeat_en;
   logic [NCH-1:0] button_level;
   logic [NCH-1:0] button_press;
   logic [NCH-1:0] button_release;
   logic [NCH-1:0] button_repeat;

   always #5 clk = ~clk;

   button_conditioner #(
      .NUM_CH          (NCH),
      .DEBOUNCE_CYCLES (DEB),
      .HOLD_CYCLES     (HOLDC),
      .REPEAT_CYCLES   (REP)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .button_in      (button_in),
      .repeat_en      (repeat_en),
      .button_level   (button_level),
      .button_press   (button_press),
      .button_release (button_release),
      .button_repeat  (button_repeat)
   );

   logic [4*NCH-1:0] expQ[$];
   int testsRun    = 0;
   int testsFailed = 0;
   int cycleNo     = 0;
   int pressSeen[NCH];
   int releaseSeen[NCH];
   int repeatSeen[NCH];

   logic [NCH-1:0] mSync1, mSync2, mLevel, mPrevS, mRepeating;
   logic [NCH-1:0] mPress, mRelease, mRepeat;
   int             mHeld[NCH];
   logic [31:0]    mHist[NCH];

   logic [4*NCH-1:0] monExp;
   logic [4*NCH-1:0] monGot;

   // A level changes once the last DEB synchronised samples all disagree with it;
   // hold time accrues only on edges where the button was and still is sampled pressed.
   task automatic modelEdge(input logic [NCH-1:0] btn, input logic [NCH-1:0] en, input logic rstn);
      logic s;
      mPress   = '0;
      mRelease = '0;
      mRepeat  = '0;
      if (!rstn) begin
         mSync1     = '0;
         mSync2     = '0;
         mLevel     = '0;
         mPrevS     = '0;
         mRepeating = '0;
         for (int c = 0; c < NCH; c++) begin
            mHeld[c] = 0;
            mHist[c] = '0;
         end
      end else begin
         for (int c = 0; c < NCH; c++) begin
            s        = mSync2[c];
            mHist[c] = {mHist[c][30:0], s};
            if (!mLevel[c] && ((mHist[c] & WIN) == WIN)) begin
               mLevel[c]     = 1'b1;
               mPress[c]     = 1'b1;
               mHeld[c]      = 0;
               mRepeating[c] = 1'b0;
            end else if (mLevel[c] && ((mHist[c] & WIN) == 32'd0)) begin
               mLevel[c]   = 1'b0;
               mRelease[c] = 1'b1;
            end else if (mLevel[c] && mPrevS[c] && s) begin
               if (!en[c]) begin
                  mHeld[c]      = 0;
                  mRepeating[c] = 1'b0;
               end else begin
                  mHeld[c]++;
                  if (mHeld[c] == (mRepeating[c] ? REP : HOLDC)) begin
                     mRepeat[c]    = 1'b1;
                     mHeld[c]      = 0;
                     mRepeating[c] = 1'b1;
                  end
               end
            end
            mPrevS[c] = s;
         end
         mSync2 = mSync1;
         mSync1 = btn;
      end
   endtask

   task automatic applyStimulus(input logic [NCH-1:0] btn, input logic [NCH-1:0] en, input logic rstn);
      @(negedge clk);
      #1;
      button_in = btn;
      repeat_en = en;
      reset     = rstn;
      modelEdge(btn, en, rstn);
      expQ.push_back({mLevel, mPress, mRelease, mRepeat});
   endtask

   task automatic holdFor(input int n, input logic [NCH-1:0] btn, input logic [NCH-1:0] en);
      for (int i = 0; i < n; i++) applyStimulus(btn, en, 1'b1);
   endtask

   task automatic checkOutput(input string name, input int got, input int want);
      testsRun++;
      if (got != want) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
      end
   endtask

   task automatic clearCounts();
      for (int c = 0; c < NCH; c++) begin
         pressSeen[c]   = 0;
         releaseSeen[c] = 0;
         repeatSeen[c]  = 0;
      end
   endtask

   always @(negedge clk) begin
      cycleNo++;
      if (expQ.size() > 0) begin
         monExp = expQ.pop_front();
         monGot = {button_level, button_press, button_release, button_repeat};
         testsRun++;
         if (monGot !== monExp) begin
            testsFailed++;
            $display("[TB] FAIL outputs cycle %0d: got lvl=%b prs=%b rel=%b rep=%b, expected lvl=%b prs=%b rel=%b rep=%b",
                     cycleNo, monGot[4*NCH-1:3*NCH], monGot[3*NCH-1:2*NCH], monGot[2*NCH-1:NCH], monGot[NCH-1:0],
                     monExp[4*NCH-1:3*NCH], monExp[3*NCH-1:2*NCH], monExp[2*NCH-1:NCH], monExp[NCH-1:0]);
         end
         for (int c = 0; c < NCH; c++) begin
            pressSeen[c]   += int'(button_press[c]);
            releaseSeen[c] += int'(button_release[c]);
            repeatSeen[c]  += int'(button_repeat[c]);
         end
      end
   end

   initial begin
      logic [NCH-1:0] rBtn;
      logic [NCH-1:0] rEn;
      logic           rRst;
      reset     = 1'b0;
      button_in = '0;
      repeat_en = '0;
      clearCounts();

      // Buttons held through reset must still debounce fully afterwards.
      for (int i = 0; i < 3; i++) applyStimulus(3'b111, 3'b000, 1'b0);
      holdFor(12, 3'b111, 3'b000);
      for (int c = 0; c < NCH; c++) checkOutput($sformatf("reset_press_ch%0d", c), pressSeen[c], 1);
      holdFor(10, 3'b000, 3'b000);

      clearCounts();
      holdFor(10, 3'b001, 3'b000);
      holdFor(10, 3'b000, 3'b000);
      checkOutput("clean_press_ch0", pressSeen[0], 1);
      checkOutput("clean_release_ch0", releaseSeen[0], 1);
      checkOutput("clean_others", pressSeen[1] + pressSeen[2] + releaseSeen[1] + releaseSeen[2], 0);

      clearCounts();
      applyStimulus(3'b010, 3'b000, 1'b1);
      applyStimulus(3'b010, 3'b000, 1'b1);
      applyStimulus(3'b000, 3'b000, 1'b1);
      applyStimulus(3'b010, 3'b000, 1'b1);
      applyStimulus(3'b010, 3'b000, 1'b1);
      applyStimulus(3'b010, 3'b000, 1'b1);
      applyStimulus(3'b000, 3'b000, 1'b1);
      checkOutput("bounce_no_press", pressSeen[1], 0);
      holdFor(10, 3'b010, 3'b000);
      checkOutput("bounce_one_press", pressSeen[1], 1);
      holdFor(2, 3'b000, 3'b000);
      holdFor(8, 3'b010, 3'b000);
      checkOutput("glitch_no_release", releaseSeen[1], 0);
      holdFor(10, 3'b000, 3'b000);
      checkOutput("bounce_release", releaseSeen[1], 1);

      // Input drops so the first sample of 0 lands exactly where the 7th repeat would be.
      clearCounts();
      holdFor(43, 3'b100, 3'b100);
      holdFor(12, 3'b000, 3'b100);
      checkOutput("repeat_count_en", repeatSeen[2], 6);
      checkOutput("repeat_press", pressSeen[2], 1);
      checkOutput("repeat_release", releaseSeen[2], 1);
      clearCounts();
      holdFor(43, 3'b100, 3'b000);
      holdFor(12, 3'b000, 3'b000);
      checkOutput("repeat_count_dis", repeatSeen[2], 0);

      holdFor(10, 3'b100, 3'b000);
      clearCounts();
      holdFor(10, 3'b011, 3'b000);
      checkOutput("simul_press_ch0", pressSeen[0], 1);
      checkOutput("simul_press_ch1", pressSeen[1], 1);
      checkOutput("simul_release_ch2", releaseSeen[2], 1);
      holdFor(10, 3'b000, 3'b000);

      clearCounts();
      holdFor(5, 3'b001, 3'b000);
      applyStimulus(3'b001, 3'b000, 1'b0);
      holdFor(10, 3'b000, 3'b000);
      checkOutput("reset_midcount_no_press", pressSeen[0], 0);
      holdFor(17, 3'b100, 3'b100);
      applyStimulus(3'b100, 3'b100, 1'b0);
      clearCounts();
      holdFor(12, 3'b100, 3'b100);
      checkOutput("reset_repeat_repress", pressSeen[2], 1);
      checkOutput("reset_repeat_no_stale", repeatSeen[2], 0);
      holdFor(10, 3'b000, 3'b000);

      rBtn = '0;
      rEn  = '0;
      for (int i = 0; i < 800; i++) begin
         for (int c = 0; c < NCH; c++) begin
            if ($urandom_range(0, 7) == 0)  rBtn[c] = ~rBtn[c];
            if ($urandom_range(0, 39) == 0) rEn[c]  = ~rEn[c];
         end
         rRst = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
         applyStimulus(rBtn, rEn, rRst);
      end

      for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge clk);
      #1;
      checkOutput("scoreboard_drained", expQ.size(), 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
